// File: rtl/pixel_lfsr_decoder.sv
// Column-side pixel readout decoder: accepts one raw pixel word, pulses the pixel
// clear line, and converts the LFSR-coded fields to binary by stepping reference LFSRs.
module pixel_lfsr_decoder #(
    parameter int CLR_CYCLES = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic       clk_40MHz,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       shutter_mode,
    input  logic [7:0] tot_code,
    input  logic [4:0] ftoa_code,
    input  logic [8:0] ts_code,
    output logic       pixel_clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       mode_out,
    output logic [7:0] tot_bin,
    output logic [4:0] ftoa_bin,
    output logic [8:0] ts_bin,
    output logic [5:0] hit_cnt,
    output logic [2:0] err
);

    typedef enum logic [1:0] {IDLE, CAPTURE, SEARCH, DONE} state_t;

    state_t     state_q;
    logic [1:0] clrCnt_q;
    logic [7:0] k_q;
    logic [7:0] totRef_q;
    logic [4:0] ftoaRef_q;
    logic [5:0] hitRef_q;
    logic       mode_q;
    logic [7:0] totCode_q;
    logic [4:0] ftoaCode_q;
    logic [8:0] tsCode_q;
    logic       totFound_q, ftoaFound_q, hitFound_q;
    logic [7:0] totRes_q;
    logic [4:0] ftoaRes_q;
    logic [5:0] hitRes_q;
    logic       inReady_q, pixelClear_q, outValid_q, modeOut_q;
    logic [7:0] totBin_q;
    logic [4:0] ftoaBin_q;
    logic [8:0] tsBin_q;
    logic [5:0] hitCnt_q;
    logic [2:0] err_q;

    logic       totMatch_d, ftoaMatch_d, hitMatch_d;
    logic       totFound_d, ftoaFound_d, hitFound_d;
    logic [7:0] totRes_d;
    logic [4:0] ftoaRes_d;
    logic [5:0] hitRes_d;
    logic       searchExit_d;

    function automatic logic [7:0] totStep(input logic [7:0] r);
        return {r[6:0], ~(r[7] ^ r[5] ^ r[4] ^ r[3])};
    endfunction

    function automatic logic [4:0] ftoaStep(input logic [4:0] r);
        return {r[3:0], ~(r[4] ^ r[2])};
    endfunction

    function automatic logic [5:0] hitStep(input logic [5:0] r);
        return {r[4:0], ~(r[5] ^ r[4])};
    endfunction

    // Short LFSRs alias after their period, so only the first lap may match.
    always_comb begin
        totMatch_d   = ~totFound_q & (totRef_q == totCode_q);
        ftoaMatch_d  = ~ftoaFound_q & (k_q < 8'd31) & (ftoaRef_q == ftoaCode_q);
        hitMatch_d   = ~hitFound_q & (k_q < 8'd63) & (hitRef_q == tsCode_q[7:2]);
        totFound_d   = totFound_q | totMatch_d;
        ftoaFound_d  = ftoaFound_q | ftoaMatch_d;
        hitFound_d   = hitFound_q | hitMatch_d;
        totRes_d     = totMatch_d ? k_q : totRes_q;
        ftoaRes_d    = ftoaMatch_d ? k_q[4:0] : ftoaRes_q;
        hitRes_d     = hitMatch_d ? k_q[5:0] : hitRes_q;
        searchExit_d = (k_q == 8'd254);
        if (EARLY_EXIT != 0) begin
            if (mode_q ? hitFound_d : (totFound_d & ftoaFound_d)) begin
                searchExit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            state_q      <= IDLE;
            clrCnt_q     <= '0;
            k_q          <= '0;
            totRef_q     <= '0;
            ftoaRef_q    <= '0;
            hitRef_q     <= '0;
            mode_q       <= 1'b0;
            totCode_q    <= '0;
            ftoaCode_q   <= '0;
            tsCode_q     <= '0;
            totFound_q   <= 1'b0;
            ftoaFound_q  <= 1'b0;
            hitFound_q   <= 1'b0;
            totRes_q     <= '0;
            ftoaRes_q    <= '0;
            hitRes_q     <= '0;
            inReady_q    <= 1'b1;
            pixelClear_q <= 1'b0;
            outValid_q   <= 1'b0;
            modeOut_q    <= 1'b0;
            totBin_q     <= '0;
            ftoaBin_q    <= '0;
            tsBin_q      <= '0;
            hitCnt_q     <= '0;
            err_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mode_q       <= shutter_mode;
                        totCode_q    <= tot_code;
                        ftoaCode_q   <= ftoa_code;
                        tsCode_q     <= ts_code;
                        inReady_q    <= 1'b0;
                        pixelClear_q <= 1'b1;
                        clrCnt_q     <= 2'(CLR_CYCLES - 1);
                        state_q      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    totRef_q    <= 8'h00;
                    ftoaRef_q   <= 5'b00001;
                    hitRef_q    <= 6'h00;
                    k_q         <= 8'd0;
                    totFound_q  <= 1'b0;
                    ftoaFound_q <= 1'b0;
                    hitFound_q  <= 1'b0;
                    totRes_q    <= '0;
                    ftoaRes_q   <= '0;
                    hitRes_q    <= '0;
                    if (clrCnt_q == 2'd0) begin
                        pixelClear_q <= 1'b0;
                        state_q      <= SEARCH;
                    end else begin
                        clrCnt_q <= clrCnt_q - 2'd1;
                    end
                end
                SEARCH: begin
                    totFound_q  <= totFound_d;
                    ftoaFound_q <= ftoaFound_d;
                    hitFound_q  <= hitFound_d;
                    totRes_q    <= totRes_d;
                    ftoaRes_q   <= ftoaRes_d;
                    hitRes_q    <= hitRes_d;
                    totRef_q    <= totStep(totRef_q);
                    ftoaRef_q   <= ftoaStep(ftoaRef_q);
                    hitRef_q    <= hitStep(hitRef_q);
                    k_q         <= k_q + 8'd1;
                    // Fields not used by the captured mode report zero and no error.
                    if (searchExit_d) begin
                        modeOut_q  <= mode_q;
                        totBin_q   <= (!mode_q && totFound_d) ? totRes_d : 8'd0;
                        ftoaBin_q  <= (!mode_q && ftoaFound_d) ? ftoaRes_d : 5'd0;
                        tsBin_q    <= mode_q ? 9'd0 : tsCode_q;
                        hitCnt_q   <= (mode_q && hitFound_d) ? hitRes_d : 6'd0;
                        err_q      <= {mode_q & ~hitFound_d,
                                       ~mode_q & ~ftoaFound_d,
                                       ~mode_q & ~totFound_d};
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake and clear lines fall as soon as reset is seen, not one edge later.
    assign in_ready    = inReady_q & ~rst;
    assign pixel_clear = pixelClear_q & ~rst;
    assign out_valid   = outValid_q & ~rst;
    assign mode_out    = modeOut_q;
    assign tot_bin     = totBin_q;
    assign ftoa_bin    = ftoaBin_q;
    assign ts_bin      = tsBin_q;
    assign hit_cnt     = hitCnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pixel_lfsr_decoder.sv
// Self-checking bench for pixel_lfsr_decoder: directed and random pixel words
// compared against a table-lookup model of the LFSR sequences.
module tb_pixel_lfsr_decoder;

    localparam int CLR   = 1;
    localparam int EARLY = 1;

    logic       clk_40MHz = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       shutter_mode = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] tot_code = '0;
    logic [4:0] ftoa_code = '0;
    logic [8:0] ts_code = '0;
    logic       in_ready, pixel_clear, out_valid, mode_out;
    logic [7:0] tot_bin;
    logic [4:0] ftoa_bin;
    logic [8:0] ts_bin;
    logic [5:0] hit_cnt;
    logic [2:0] err;

    int checks = 0;
    int errors = 0;

    // Position of each code in its sequence, -1 if never reached within its window.
    int totPos[256];
    int ftoaPos[32];
    int hitPos[64];

    pixel_lfsr_decoder #(.CLR_CYCLES(CLR), .EARLY_EXIT(EARLY)) dut (
        .clk_40MHz(clk_40MHz), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .shutter_mode(shutter_mode), .tot_code(tot_code), .ftoa_code(ftoa_code),
        .ts_code(ts_code), .pixel_clear(pixel_clear), .out_valid(out_valid),
        .out_ready(out_ready), .mode_out(mode_out), .tot_bin(tot_bin),
        .ftoa_bin(ftoa_bin), .ts_bin(ts_bin), .hit_cnt(hit_cnt), .err(err)
    );

    always #12 clk_40MHz = ~clk_40MHz;

    task automatic buildTables();
        logic [7:0] rt;
        logic [4:0] rf;
        logic [5:0] rh;
        foreach (totPos[i]) totPos[i] = -1;
        foreach (ftoaPos[i]) ftoaPos[i] = -1;
        foreach (hitPos[i]) hitPos[i] = -1;
        rt = 8'h00;
        rf = 5'b00001;
        rh = 6'h00;
        for (int k = 0; k < 255; k++) begin
            if (totPos[rt] < 0) totPos[rt] = k;
            if (k < 31 && ftoaPos[rf] < 0) ftoaPos[rf] = k;
            if (k < 63 && hitPos[rh] < 0) hitPos[rh] = k;
            rt = {rt[6:0], ~(rt[7] ^ rt[5] ^ rt[4] ^ rt[3])};
            rf = {rf[3:0], ~(rf[4] ^ rf[2])};
            rh = {rh[4:0], ~(rh[5] ^ rh[4])};
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag, input logic expReady);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(expReady));
        checkOutput({tag, "_pixel_clear"}, 32'(pixel_clear), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_data"}, 32'({mode_out, tot_bin, ftoa_bin, ts_bin, hit_cnt, err}), 32'd0);
    endtask

    // Present one word when the decoder is ready; returns one cycle after acceptance.
    task automatic applyStimulus(input logic mode, input logic [7:0] tot,
                                 input logic [4:0] ftoa, input logic [8:0] ts);
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk_40MHz);
            w++;
        end
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        shutter_mode = mode;
        tot_code     = tot;
        ftoa_code    = ftoa;
        ts_code      = ts;
        in_valid     = 1'b1;
        @(negedge clk_40MHz);
        in_valid     = 1'b0;
        shutter_mode = ~mode;
        tot_code     = 8'($urandom);
        ftoa_code    = 5'($urandom);
        ts_code      = 9'($urandom);
    endtask

    task automatic runDecode(input logic mode, input logic [7:0] tot, input logic [4:0] ftoa,
                             input logic [8:0] ts, input int stall);
        int jt, jf, jh, maxJ, expLat, t;
        logic allFound;
        logic [7:0] eTot;
        logic [4:0] eFtoa;
        logic [8:0] eTs;
        logic [5:0] eHit;
        logic [2:0] eErr;
        logic [31:0] expWord;

        jt = totPos[tot];
        jf = ftoaPos[ftoa];
        jh = hitPos[ts[7:2]];
        if (!mode) begin
            eTot     = (jt >= 0) ? 8'(jt) : 8'd0;
            eFtoa    = (jf >= 0) ? 5'(jf) : 5'd0;
            eTs      = ts;
            eHit     = 6'd0;
            eErr     = {1'b0, jf < 0, jt < 0};
            allFound = (jt >= 0) && (jf >= 0);
            maxJ     = (jt > jf) ? jt : jf;
        end else begin
            eTot     = 8'd0;
            eFtoa    = 5'd0;
            eTs      = 9'd0;
            eHit     = (jh >= 0) ? 6'(jh) : 6'd0;
            eErr     = {jh < 0, 2'b00};
            allFound = (jh >= 0);
            maxJ     = jh;
        end
        expLat  = (EARLY != 0 && allFound) ? 2 + CLR + maxJ : 1 + CLR + 255;
        expWord = 32'({mode, eTot, eFtoa, eTs, eHit, eErr});

        applyStimulus(mode, tot, ftoa, ts);
        t = 1;
        while (out_valid !== 1'b1 && t < 300) begin
            checkOutput("pixel_clear_window", 32'(pixel_clear), 32'(t <= CLR));
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk_40MHz);
            t++;
        end
        checkOutput("latency", 32'(t), 32'(expLat));
        checkOutput("decoded_word",
                    32'({mode_out, tot_bin, ftoa_bin, ts_bin, hit_cnt, err}), expWord);

        // Backpressure: a new word offered while DONE must be ignored.
        for (int s = 0; s < stall; s++) begin
            in_valid     = 1'b1;
            shutter_mode = 1'($urandom);
            tot_code     = 8'($urandom);
            @(negedge clk_40MHz);
            checkOutput("stall_word",
                        32'({mode_out, tot_bin, ftoa_bin, ts_bin, hit_cnt, err}), expWord);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_pixel_clear", 32'(pixel_clear), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk_40MHz);
        out_ready = 1'b0;
        checkOutput("post_xfer_valid", 32'(out_valid), 32'd0);
        checkOutput("post_xfer_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_xfer_pixel_clear", 32'(pixel_clear), 32'd0);
    endtask

    initial begin
        logic       rMode;
        logic [7:0] rTot;
        logic [4:0] rFtoa;
        logic [8:0] rTs;

        buildTables();

        rst = 1'b1;
        repeat (3) begin
            @(posedge clk_40MHz);
            @(negedge clk_40MHz);
            checkIdleOutputs("reset", 1'b0);
        end
        rst = 1'b0;
        @(negedge clk_40MHz);
        checkIdleOutputs("after_reset", 1'b1);

        runDecode(1'b0, 8'h03, 5'b00001, 9'h1A5, 0);
        runDecode(1'b1, 8'($urandom), 5'($urandom), {1'($urandom), 6'b000011, 2'($urandom)}, 0);
        runDecode(1'b0, 8'hFF, 5'b00011, 9'h0F0, 10);
        runDecode(1'b1, 8'h03, 5'h01, {1'b0, 6'h3F, 2'b01}, 1);
        runDecode(1'b0, 8'h40, 5'h1F, 9'h155, 0);

        // Abort a lockup search at k=100 with reset.
        applyStimulus(1'b0, 8'hFF, 5'h03, 9'h0AA);
        repeat (101) @(negedge clk_40MHz);
        rst = 1'b1;
        @(negedge clk_40MHz);
        checkOutput("mid_rst_pixel_clear", 32'(pixel_clear), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk_40MHz);
        checkIdleOutputs("after_mid_rst", 1'b1);
        runDecode(1'b0, 8'h03, 5'b00001, 9'h1A5, 0);

        for (int n = 0; n < 12; n++) begin
            rMode = 1'($urandom);
            rTot  = (($urandom % 8) == 0) ? 8'hFF : 8'($urandom);
            rFtoa = (($urandom % 8) == 0) ? 5'h1F : 5'($urandom);
            rTs   = 9'($urandom);
            runDecode(rMode, rTot, rFtoa, rTs, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
